// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction-side cache: word type, fill FSM states and line frame.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IBYT_W = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE,
        FILL
    } icache_state_t;

    // The tag field holds the full word address so the frame stays independent of SETS.
    // The index bits inside it always match the selected line.
    typedef struct packed {
        logic                       valid;
        logic [WORD_W-IBYT_W-1:0]   tag;
        word_t                      data;
    } icache_frame_t;

endpackage

// File: rtl/icache_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module icache_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-line, read-only instruction cache. Hits answer in the same cycle;
// misses run a fill over the iREN/iwait handshake that is never aborted once started.
module icache_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS  = 16,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int unsigned TAG_W = WORD_W - IBYT_W;

    icache_state_t state_q, state_d;
    word_t         miss_q, miss_d;
    logic          fill_we;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    word_t            data_q [SETS];

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] fill_idx;
    icache_frame_t    lookup;
    logic             hit;

    // Byte offset is meaningless for word fetches.
    logic unused_byte_off;
    assign unused_byte_off = ^imemaddr[IBYT_W-1:0];

    assign idx      = imemaddr[IDX_W+IBYT_W-1:IBYT_W];
    assign fill_idx = miss_q[IDX_W+IBYT_W-1:IBYT_W];

    always_comb begin
        lookup       = '0;
        lookup.valid = valid_q[idx];
        lookup.tag   = tag_q[idx];
        lookup.data  = data_q[idx];
    end

    assign hit      = imemREN && lookup.valid && (lookup.tag == imemaddr[WORD_W-1:IBYT_W]);
    assign imemload = lookup.data;

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        ihit    = 1'b0;
        iREN    = 1'b0;
        iaddr   = '0;
        fill_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    ihit = 1'b1;
                end else if (imemREN) begin
                    miss_d  = {imemaddr[WORD_W-1:IBYT_W], {IBYT_W{1'b0}}};
                    state_d = FILL;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = miss_q;
                if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data carry no reset; valid_q alone qualifies them.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= miss_q[WORD_W-1:IBYT_W];
            data_q[fill_idx] <= iload;
        end
    end

    icache_counter #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (1'b0),
        .inc   (ihit),
        .count (hit_count)
    );

    icache_counter #(
        .CNT_W (CNT_W)
    ) u_miss_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (1'b0),
        .inc   (fill_we),
        .count (miss_count)
    );

endmodule
